// File: rtl/psum_word_packer.sv
// psum_word_packer
//
// Packs RATIO = OUT_WIDTH/IN_WIDTH narrow partial-sum words into one wide
// word and pushes it into the downstream width-converting FIFO. At the end
// of a processing pass, a flush pulse pushes any partially filled word with
// its unfilled lanes zero-padded, then reports completion on flush_done.
//
// Ports:
//   clk                 clock; all state updates on the rising edge
//   reset               synchronous, active-high reset
//   in_valid            incoming psum word valid
//   in_data             incoming psum word (IN_WIDTH bits)
//   in_ready            packer can accept in_data this cycle
//   flush               single-cycle pulse: push any partial word, then report
//   fifo_full           downstream FIFO full flag
//   fifo_write_request  write strobe to the downstream FIFO
//   fifo_wr_data        packed word to the downstream FIFO (OUT_WIDTH bits)
//   flush_done          one-cycle pulse: flush completed
//   lane_count          number of lanes currently filled in the pack register
//   busy                high while pushing or while a partial word is held
//
// Lane 0 (the first accepted word) occupies bits [IN_WIDTH-1:0]. Lane k
// occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH], which matches the reader
// side because it unpacks lane 0 first.

module psum_word_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 64,
  parameter int LANE_BITS = $clog2(OUT_WIDTH / IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 fifo_full,
  output logic                 fifo_write_request,
  output logic [OUT_WIDTH-1:0] fifo_wr_data,
  output logic                 flush_done,
  output logic [LANE_BITS-1:0] lane_count,
  output logic                 busy
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;

  typedef enum logic {
    ACCUM = 1'b0,
    PUSH  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [OUT_WIDTH-1:0] pack_reg;
  logic [OUT_WIDTH-1:0] pack_next;
  logic [LANE_BITS-1:0] lane_next;
  logic                 flush_pending;
  logic                 pend_next;
  logic                 done_next;
  logic                 write_ok;
  logic                 pend_eff;

  // A flush arriving this cycle counts as already pending, so an idle flush
  // completes one cycle later and a flush landing on the write cycle merges
  // into that write's flush_done.
  assign pend_eff     = flush_pending | flush;
  assign fifo_wr_data = pack_reg;
  assign busy         = (state == PUSH) || (lane_count != '0);

  // Next-state and output logic. All next values default to "hold", with
  // the flush request latched, and each state overrides what it changes.
  always_comb begin
    state_next = state;
    pack_next  = pack_reg;
    lane_next  = lane_count;
    pend_next  = pend_eff;
    done_next  = 1'b0;
    in_ready   = 1'b0;
    write_ok   = 1'b0;

    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int k = 0; k < RATIO; k++) begin
            if (lane_count == LANE_BITS'(k)) begin
              pack_next[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
          end
          // The lane counter is a power-of-two width, so it wraps to 0 on the
          // word-completing accept by itself.
          lane_next = lane_count + LANE_BITS'(1);
          if (lane_count == LANE_BITS'(RATIO - 1)) begin
            state_next = PUSH;
          end
        end
        // A word-completing accept already heads to PUSH and keeps the flush
        // pending, so it yields exactly one write and no padded extra one.
        if (state_next == ACCUM && pend_eff) begin
          if (lane_next != '0) begin
            state_next = PUSH;
            lane_next  = '0;
          end else begin
            done_next = 1'b1;
            pend_next = 1'b0;
          end
        end
      end

      PUSH: begin
        if (!fifo_full) begin
          write_ok   = 1'b1;
          // Clearing after every write is what zero-pads a flushed partial word.
          pack_next  = '0;
          state_next = ACCUM;
          if (pend_eff) begin
            done_next = 1'b1;
            pend_next = 1'b0;
          end
        end
      end

      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // A write strobe must never escape while reset is held, whatever the state.
  assign fifo_write_request = write_ok & ~reset;

  // State register. Reset discards any partially packed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ACCUM;
      pack_reg      <= '0;
      lane_count    <= '0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      state         <= state_next;
      pack_reg      <= pack_next;
      lane_count    <= lane_next;
      flush_pending <= pend_next;
      flush_done    <= done_next;
    end
  end

endmodule
